// File: rtl/fpu_fp16_to_int.sv
// FP16 to signed INTW-bit integer converter: iterative 1-bit/cycle aligner, RNE rounding, {NV,OF,NX} flags.
// Optional macro FPU_CVT_TRUNC_EN adds truncIn to select round-toward-zero per operation.

package fpu_fp16_to_int_pkg;
  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } cvtState_t;
endpackage

module fpu_fp16_to_int
  import fpu_fp16_to_int_pkg::*;
#(
  parameter int unsigned INTW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inValid,
  output logic            inReady,
  input  fp16_t           fpIn,
`ifdef FPU_CVT_TRUNC_EN
  input  logic            truncIn,
`endif
  output logic            outValid,
  input  logic            outReady,
  output logic [INTW-1:0] intOut,
  output logic [2:0]      cvtFlags
);

  localparam int unsigned MagW    = 17;
  localparam int unsigned CntW    = 4;
  localparam int unsigned WideW   = 33;
  localparam logic [WideW-1:0] posMaxWide = WideW'((64'd1 << (INTW - 1)) - 64'd1);
  localparam logic [WideW-1:0] negMagWide = WideW'(64'd1 << (INTW - 1));
  localparam logic [INTW-1:0]  posMaxInt  = INTW'(posMaxWide);
  localparam logic [INTW-1:0]  negMinInt  = {1'b1, {(INTW - 1){1'b0}}};

  cvtState_t           state, nextState;
  logic [MagW-1:0]     mag, nextMag;
  logic [CntW-1:0]     cnt, nextCnt;
  logic                shiftLeft, nextShiftLeft;
  logic                guard, nextGuard;
  logic                sticky, nextSticky;
  logic                signReg, nextSign;
  logic [INTW-1:0]     nextIntOut;
  logic [2:0]          nextFlags;
  logic                nextInReady, nextOutValid;
  logic                truncReg;

  logic                accept;
  logic                isNan, isInf, isZero, isSpecial;
  logic [4:0]          expEff, rightRaw, shAmt;
  logic                leftDir;
  logic                roundUp, ovf;
  logic [MagW:0]       rounded;
  logic [INTW-1:0]     roundedInt;

  assign accept = inValid & inReady;

  // Operand classification and alignment setup
  always_comb begin
    isNan     = (fpIn.exp == 5'h1f) && (fpIn.frac != 10'd0);
    isInf     = (fpIn.exp == 5'h1f) && (fpIn.frac == 10'd0);
    isZero    = (fpIn.exp == 5'd0)  && (fpIn.frac == 10'd0);
    isSpecial = isNan | isInf | isZero;
    expEff    = (fpIn.exp == 5'd0) ? 5'd1 : fpIn.exp;
    leftDir   = (expEff >= 5'd25);
    rightRaw  = 5'd25 - expEff;
    if (leftDir) begin
      shAmt = expEff - 5'd25;
    end else if (rightRaw > 5'd12) begin
      shAmt = 5'd12;
    end else begin
      shAmt = rightRaw;
    end
  end

  // Rounding and range check on the aligned magnitude
  always_comb begin
    roundUp    = guard & (sticky | mag[0]) & ~truncReg;
    rounded    = (MagW + 1)'(mag) + (MagW + 1)'(roundUp);
    ovf        = signReg ? ((WideW'(rounded)) > negMagWide)
                         : ((WideW'(rounded)) > posMaxWide);
    roundedInt = INTW'(rounded);
  end

`ifdef FPU_CVT_TRUNC_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      truncReg <= 1'b0;
    end else if (accept) begin
      truncReg <= truncIn;
    end
  end
`else
  assign truncReg = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isSpecial) begin
            nextState = DONE;
          end else if (shAmt != 5'd0) begin
            nextState = SHIFT;
          end else begin
            nextState = ROUND;
          end
        end
      end
      SHIFT: begin
        if (cnt == CntW'(1)) begin
          nextState = ROUND;
        end
      end
      ROUND:   nextState = DONE;
      DONE: begin
        if (outReady) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    nextMag       = mag;
    nextCnt       = cnt;
    nextShiftLeft = shiftLeft;
    nextGuard     = guard;
    nextSticky    = sticky;
    nextSign      = signReg;
    nextIntOut    = intOut;
    nextFlags     = cvtFlags;
    nextInReady   = (nextState == IDLE);
    nextOutValid  = (nextState == DONE);
    case (state)
      IDLE: begin
        if (accept) begin
          nextSign      = fpIn.sign;
          nextMag       = MagW'({(fpIn.exp != 5'd0), fpIn.frac});
          nextCnt       = CntW'(shAmt);
          nextShiftLeft = leftDir;
          nextGuard     = 1'b0;
          nextSticky    = 1'b0;
          if (isNan) begin
            nextIntOut = posMaxInt;
            nextFlags  = 3'b100;
          end else if (isInf) begin
            nextIntOut = fpIn.sign ? negMinInt : posMaxInt;
            nextFlags  = 3'b010;
          end else if (isZero) begin
            nextIntOut = '0;
            nextFlags  = 3'b000;
          end
        end
      end
      SHIFT: begin
        nextCnt = cnt - CntW'(1);
        if (shiftLeft) begin
          nextMag = {mag[MagW-2:0], 1'b0};
        end else begin
          nextMag    = {1'b0, mag[MagW-1:1]};
          nextGuard  = mag[0];
          nextSticky = sticky | guard;
        end
      end
      ROUND: begin
        if (ovf) begin
          nextIntOut = signReg ? negMinInt : posMaxInt;
        end else if (signReg) begin
          nextIntOut = -roundedInt;
        end else begin
          nextIntOut = roundedInt;
        end
        nextFlags = {1'b0, ovf, (guard | sticky) & ~ovf};
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag       <= '0;
      cnt       <= '0;
      shiftLeft <= 1'b0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      signReg   <= 1'b0;
      intOut    <= '0;
      cvtFlags  <= '0;
      inReady   <= 1'b1;
      outValid  <= 1'b0;
    end else begin
      mag       <= nextMag;
      cnt       <= nextCnt;
      shiftLeft <= nextShiftLeft;
      guard     <= nextGuard;
      sticky    <= nextSticky;
      signReg   <= nextSign;
      intOut    <= nextIntOut;
      cvtFlags  <= nextFlags;
      inReady   <= nextInReady;
      outValid  <= nextOutValid;
    end
  end

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Scoreboard bench for fpu_fp16_to_int: INTW=32 and INTW=16 instances run in lockstep on the same stimulus.
module tb_fpu_fp16_to_int;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [15:0] fpIn = 16'h0000;
  logic        outReady = 1'b1;
  logic        inReady32, outValid32, inReady16, outValid16;
  logic [31:0] intOut32;
  logic [15:0] intOut16;
  logic [2:0]  flags32, flags16;

  typedef struct {
    logic [15:0] fp;
    logic [31:0] r32;
    logic [2:0]  f32;
    logic [15:0] r16;
    logic [2:0]  f16;
    int          lat;
  } expect_t;

  expect_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCyc = 0;
  bit seen = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fpu_fp16_to_int #(.INTW(32)) dut32 (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady32), .fpIn(fpIn),
`ifdef FPU_CVT_TRUNC_EN
    .truncIn(1'b0),
`endif
    .outValid(outValid32), .outReady(outReady), .intOut(intOut32), .cvtFlags(flags32));

  fpu_fp16_to_int #(.INTW(16)) dut16 (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady16), .fpIn(fpIn),
`ifdef FPU_CVT_TRUNC_EN
    .truncIn(1'b0),
`endif
    .outValid(outValid16), .outReady(outReady), .intOut(intOut16), .cvtFlags(flags16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented result against the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && (outValid32 || outValid16)) begin
      if (q.size() == 0) begin
        check("unexpected_output", {31'd0, outValid32}, 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check($sformatf("latency_%h", q[0].fp), 32'(cyc - acceptCyc + 1), 32'(q[0].lat));
          check("valid_lockstep", {31'd0, outValid16}, {31'd0, outValid32});
        end
        check($sformatf("int32_%h", q[0].fp), intOut32, q[0].r32);
        check($sformatf("flags32_%h", q[0].fp), {29'd0, flags32}, {29'd0, q[0].f32});
        check($sformatf("int16_%h", q[0].fp), {16'd0, intOut16}, {16'd0, q[0].r16});
        check($sformatf("flags16_%h", q[0].fp), {29'd0, flags16}, {29'd0, q[0].f16});
        check("inReady_busy", {31'd0, inReady32 | inReady16}, 32'd0);
        if (outReady) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [15:0] fp, input logic [31:0] r32, input logic [2:0] f32,
                      input logic [15:0] r16, input logic [2:0] f16, input int lat);
    expect_t e;
    int n = 0;
    while (!inReady32 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!inReady32) check("inReady_timeout", 32'd0, 32'd1);
    e.fp = fp; e.r32 = r32; e.f32 = f32; e.r16 = r16; e.f16 = f16; e.lat = lat;
    q.push_back(e);
    inValid = 1'b1;
    fpIn = fp;
    @(posedge clock); #1;
    acceptCyc = cyc;
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_inReady", {31'd0, inReady32}, 32'd1);
    check("rst_outValid", {31'd0, outValid32}, 32'd0);
    check("rst_intOut", intOut32, 32'd0);
    check("rst_flags", {29'd0, flags32}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    send(16'h3E00, 32'h00000002, 3'b001, 16'h0002, 3'b001, 12);
    send(16'h4100, 32'h00000002, 3'b001, 16'h0002, 3'b001, 11);
    send(16'hC200, 32'hFFFFFFFD, 3'b000, 16'hFFFD, 3'b000, 11);
    send(16'h7BFF, 32'h0000FFE0, 3'b000, 16'h7FFF, 3'b010, 7);
    send(16'h7E00, 32'h7FFFFFFF, 3'b100, 16'h7FFF, 3'b100, 1);
    send(16'hFC00, 32'h80000000, 3'b010, 16'h8000, 3'b010, 1);
    send(16'h7C00, 32'h7FFFFFFF, 3'b010, 16'h7FFF, 3'b010, 1);
    send(16'h8000, 32'h00000000, 3'b000, 16'h0000, 3'b000, 1);
    send(16'h0000, 32'h00000000, 3'b000, 16'h0000, 3'b000, 1);
    send(16'h0001, 32'h00000000, 3'b001, 16'h0000, 3'b001, 14);
    send(16'hB800, 32'h00000000, 3'b001, 16'h0000, 3'b001, 13);
    send(16'h3A00, 32'h00000001, 3'b001, 16'h0001, 3'b001, 13);
    send(16'h3C00, 32'h00000001, 3'b000, 16'h0001, 3'b000, 12);
    send(16'h6400, 32'h00000400, 3'b000, 16'h0400, 3'b000, 2);
    send(16'h7800, 32'h00008000, 3'b000, 16'h7FFF, 3'b010, 7);
    send(16'hF800, 32'hFFFF8000, 3'b000, 16'h8000, 3'b000, 7);
    drain();

    // Backpressure: result must hold while a second operand is offered and ignored
    outReady = 1'b0;
    send(16'hC700, 32'hFFFFFFF9, 3'b000, 16'hFFF9, 3'b000, 10);
    repeat (10) @(posedge clock);
    #1;
    inValid = 1'b1;
    fpIn = 16'h3C00;
    repeat (5) @(posedge clock);
    #1;
    inValid = 1'b0;
    outReady = 1'b1;
    drain();

    // Reset in the middle of a long right shift
    send(16'h0001, 32'h00000000, 3'b001, 16'h0000, 3'b001, 14);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_outValid", {31'd0, outValid32}, 32'd0);
    check("midrst_inReady", {31'd0, inReady32}, 32'd1);
    check("midrst_intOut", intOut32, 32'd0);
    q.delete();
    seen = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    send(16'h4100, 32'h00000002, 3'b001, 16'h0002, 3'b001, 11);
    drain();

    repeat (20) @(posedge clock);
    #1;
    check("idle_outValid", {31'd0, outValid32 | outValid16}, 32'd0);
    check("idle_inReady", {31'd0, inReady32 & inReady16}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
